// File: rtl/pipelined_ctrl_unit_if.sv
// Decode-stage instruction fields, hazard controls and per-stage control outputs
// of the pipelined MIPS control unit.
interface pipelined_ctrl_unit_if #(
  parameter int ALUOP_W = 3
);
  logic [5:0]         op;
  logic [5:0]         funct;
  logic [4:0]         rt;
  logic               stall_e;
  logic               flush_e;

  logic               branch_d;
  logic [2:0]         br_cond_d;
  logic               jump_d;
  logic               jump_r_d;
  logic               illegal_d;
  logic               mdu_stall;

  logic               reg_write_e;
  logic               reg_write_m;
  logic               reg_write_w;
  logic               mem_to_reg_e;
  logic               mem_to_reg_m;
  logic               mem_to_reg_w;
  logic               mem_write_e;
  logic               mem_write_m;
  logic               alu_src_e;
  logic               reg_dst_e;
  logic [ALUOP_W-1:0] alu_op_e;
  logic               mdu_start_e;
  logic               mdu_busy;

  modport master (
    output op, funct, rt, stall_e, flush_e,
    input  branch_d, br_cond_d, jump_d, jump_r_d, illegal_d, mdu_stall,
    input  reg_write_e, reg_write_m, reg_write_w,
    input  mem_to_reg_e, mem_to_reg_m, mem_to_reg_w,
    input  mem_write_e, mem_write_m, alu_src_e, reg_dst_e, alu_op_e,
    input  mdu_start_e, mdu_busy
  );

  modport slave (
    input  op, funct, rt, stall_e, flush_e,
    output branch_d, br_cond_d, jump_d, jump_r_d, illegal_d, mdu_stall,
    output reg_write_e, reg_write_m, reg_write_w,
    output mem_to_reg_e, mem_to_reg_m, mem_to_reg_w,
    output mem_write_e, mem_write_m, alu_src_e, reg_dst_e, alu_op_e,
    output mdu_start_e, mdu_busy
  );
endinterface

// File: rtl/pipelined_ctrl_unit.sv
// MIPS control unit: decodes in D, carries the control bundle through E/M/W,
// and interlocks MDU / HI-LO instructions against an in-flight MULT/DIV.
module pipelined_ctrl_unit #(
  parameter int ALUOP_W = 3,
  parameter int MDU_LAT = 4,
  parameter int CNT_W   = 4
) (
  input logic                  clk,
  input logic                  rst,
  pipelined_ctrl_unit_if.slave bus
);

  localparam logic [5:0] OP_RTYPE  = 6'b000000;
  localparam logic [5:0] OP_REGIMM = 6'b000001;
  localparam logic [5:0] OP_J      = 6'b000010;
  localparam logic [5:0] OP_BEQ    = 6'b000100;
  localparam logic [5:0] OP_BNE    = 6'b000101;
  localparam logic [5:0] OP_BLEZ   = 6'b000110;
  localparam logic [5:0] OP_BGTZ   = 6'b000111;
  localparam logic [5:0] OP_ADDI   = 6'b001000;
  localparam logic [5:0] OP_ADDIU  = 6'b001001;
  localparam logic [5:0] OP_SLTI   = 6'b001010;
  localparam logic [5:0] OP_SLTIU  = 6'b001011;
  localparam logic [5:0] OP_ANDI   = 6'b001100;
  localparam logic [5:0] OP_ORI    = 6'b001101;
  localparam logic [5:0] OP_XORI   = 6'b001110;
  localparam logic [5:0] OP_LUI    = 6'b001111;
  localparam logic [5:0] OP_LW     = 6'b100011;
  localparam logic [5:0] OP_SW     = 6'b101011;

  localparam logic [5:0] FN_SLL   = 6'b000000;
  localparam logic [5:0] FN_SRL   = 6'b000010;
  localparam logic [5:0] FN_SRA   = 6'b000011;
  localparam logic [5:0] FN_SLLV  = 6'b000100;
  localparam logic [5:0] FN_SRLV  = 6'b000110;
  localparam logic [5:0] FN_SRAV  = 6'b000111;
  localparam logic [5:0] FN_JR    = 6'b001000;
  localparam logic [5:0] FN_MFHI  = 6'b010000;
  localparam logic [5:0] FN_MFLO  = 6'b010010;
  localparam logic [5:0] FN_MULT  = 6'b011000;
  localparam logic [5:0] FN_MULTU = 6'b011001;
  localparam logic [5:0] FN_DIV   = 6'b011010;
  localparam logic [5:0] FN_DIVU  = 6'b011011;
  localparam logic [5:0] FN_ADD   = 6'b100000;
  localparam logic [5:0] FN_ADDU  = 6'b100001;
  localparam logic [5:0] FN_SUB   = 6'b100010;
  localparam logic [5:0] FN_SUBU  = 6'b100011;
  localparam logic [5:0] FN_AND   = 6'b100100;
  localparam logic [5:0] FN_OR    = 6'b100101;
  localparam logic [5:0] FN_XOR   = 6'b100110;
  localparam logic [5:0] FN_NOR   = 6'b100111;
  localparam logic [5:0] FN_SLT   = 6'b101010;
  localparam logic [5:0] FN_SLTU  = 6'b101011;

  localparam logic [2:0] ALU_ADD   = 3'd0;
  localparam logic [2:0] ALU_LUI   = 3'd1;
  localparam logic [2:0] ALU_RTYPE = 3'd2;
  localparam logic [2:0] ALU_AND   = 3'd3;
  localparam logic [2:0] ALU_OR    = 3'd4;
  localparam logic [2:0] ALU_XOR   = 3'd5;
  localparam logic [2:0] ALU_SLTU  = 3'd6;
  localparam logic [2:0] ALU_SLT   = 3'd7;

  typedef struct packed {
    logic               reg_write;
    logic               mem_to_reg;
    logic               mem_write;
    logic               alu_src;
    logic               reg_dst;
    logic [ALUOP_W-1:0] alu_op;
  } ctrl_t;

  ctrl_t            d_ctrl;
  ctrl_t            e_ctrl;
  logic [2:0]       d_alu_code;
  logic             d_mdu;
  logic             d_hilo;
  logic             d_branch;
  logic [2:0]       d_br_cond;
  logic             d_jump;
  logic             d_jump_r;
  logic             d_illegal;

  logic             m_reg_write;
  logic             m_mem_to_reg;
  logic             m_mem_write;
  logic             w_reg_write;
  logic             w_mem_to_reg;

  logic [CNT_W-1:0] mdu_cnt;
  logic             start_e;
  logic             busy;
  logic             stall_mdu;

  always_comb begin
    d_ctrl     = '0;
    d_alu_code = ALU_ADD;
    d_mdu      = 1'b0;
    d_hilo     = 1'b0;
    d_branch   = 1'b0;
    d_br_cond  = '0;
    d_jump     = 1'b0;
    d_jump_r   = 1'b0;
    d_illegal  = 1'b0;
    case (bus.op)
      OP_RTYPE: begin
        case (bus.funct)
          FN_JR: begin
            d_jump   = 1'b1;
            d_jump_r = 1'b1;
          end
          FN_MULT, FN_MULTU, FN_DIV, FN_DIVU: begin
            d_ctrl.reg_dst = 1'b1;
            d_alu_code     = ALU_RTYPE;
            d_mdu          = 1'b1;
          end
          FN_MFHI, FN_MFLO: begin
            d_ctrl.reg_write = 1'b1;
            d_ctrl.reg_dst   = 1'b1;
            d_alu_code       = ALU_RTYPE;
            d_hilo           = 1'b1;
          end
          FN_SLL, FN_SRL, FN_SRA, FN_SLLV, FN_SRLV, FN_SRAV,
          FN_ADD, FN_ADDU, FN_SUB, FN_SUBU, FN_AND, FN_OR,
          FN_XOR, FN_NOR, FN_SLT, FN_SLTU: begin
            d_ctrl.reg_write = 1'b1;
            d_ctrl.reg_dst   = 1'b1;
            d_alu_code       = ALU_RTYPE;
          end
          default: d_illegal = 1'b1;
        endcase
      end
      OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI, OP_XORI, OP_LUI: begin
        d_ctrl.reg_write = 1'b1;
        d_ctrl.alu_src   = 1'b1;
        case (bus.op)
          OP_SLTI:  d_alu_code = ALU_SLT;
          OP_SLTIU: d_alu_code = ALU_SLTU;
          OP_ANDI:  d_alu_code = ALU_AND;
          OP_ORI:   d_alu_code = ALU_OR;
          OP_XORI:  d_alu_code = ALU_XOR;
          OP_LUI:   d_alu_code = ALU_LUI;
          default:  d_alu_code = ALU_ADD;
        endcase
      end
      OP_LW: begin
        d_ctrl.reg_write  = 1'b1;
        d_ctrl.mem_to_reg = 1'b1;
        d_ctrl.alu_src    = 1'b1;
      end
      OP_SW: begin
        d_ctrl.mem_write = 1'b1;
        d_ctrl.alu_src   = 1'b1;
      end
      OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ: begin
        d_branch  = 1'b1;
        d_br_cond = {1'b0, bus.op[1:0]};
      end
      OP_REGIMM: begin
        // only bltz/bgez exist here; the linking variants are not supported
        if (bus.rt[4:1] == 4'b0000) begin
          d_branch  = 1'b1;
          d_br_cond = {2'b10, bus.rt[0]};
        end else begin
          d_illegal = 1'b1;
        end
      end
      OP_J:    d_jump    = 1'b1;
      default: d_illegal = 1'b1;
    endcase
    d_ctrl.alu_op = ALUOP_W'(d_alu_code);
  end

  assign busy      = (mdu_cnt != '0);
  assign stall_mdu = (busy | start_e) & (d_mdu | d_hilo);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      e_ctrl       <= '0;
      m_reg_write  <= 1'b0;
      m_mem_to_reg <= 1'b0;
      m_mem_write  <= 1'b0;
      w_reg_write  <= 1'b0;
      w_mem_to_reg <= 1'b0;
      mdu_cnt      <= '0;
      start_e      <= 1'b0;
    end else begin
      // the countdown runs through stalls; a new load below takes precedence
      if (mdu_cnt != '0) mdu_cnt <= mdu_cnt - CNT_W'(1);
      if (bus.stall_e) begin
        start_e <= 1'b0;
      end else begin
        w_reg_write  <= m_reg_write;
        w_mem_to_reg <= m_mem_to_reg;
        m_reg_write  <= e_ctrl.reg_write;
        m_mem_to_reg <= e_ctrl.mem_to_reg;
        m_mem_write  <= e_ctrl.mem_write;
        if (bus.flush_e || stall_mdu) begin
          e_ctrl  <= '0;
          start_e <= 1'b0;
        end else begin
          e_ctrl  <= d_ctrl;
          start_e <= d_mdu;
          if (d_mdu) mdu_cnt <= CNT_W'(MDU_LAT);
        end
      end
    end
  end

  assign bus.branch_d     = d_branch;
  assign bus.br_cond_d    = d_br_cond;
  assign bus.jump_d       = d_jump;
  assign bus.jump_r_d     = d_jump_r;
  assign bus.illegal_d    = d_illegal;
  assign bus.mdu_stall    = stall_mdu;
  assign bus.reg_write_e  = e_ctrl.reg_write;
  assign bus.mem_to_reg_e = e_ctrl.mem_to_reg;
  assign bus.mem_write_e  = e_ctrl.mem_write;
  assign bus.alu_src_e    = e_ctrl.alu_src;
  assign bus.reg_dst_e    = e_ctrl.reg_dst;
  assign bus.alu_op_e     = e_ctrl.alu_op;
  assign bus.reg_write_m  = m_reg_write;
  assign bus.mem_to_reg_m = m_mem_to_reg;
  assign bus.mem_write_m  = m_mem_write;
  assign bus.reg_write_w  = w_reg_write;
  assign bus.mem_to_reg_w = w_mem_to_reg;
  assign bus.mdu_start_e  = start_e;
  assign bus.mdu_busy     = busy;

endmodule

// File: tb/tb_pipelined_ctrl_unit.sv
// Directed plus random stimulus for pipelined_ctrl_unit, checked against a
// cycle-indexed reference model of decode, pipeline staging and MDU occupancy.
module tb_pipelined_ctrl_unit;
  localparam int ALUOP_W = 3;
  localparam int MDU_LAT = 4;
  localparam int CNT_W   = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pipelined_ctrl_unit_if #(.ALUOP_W(ALUOP_W)) bus ();

  pipelined_ctrl_unit #(.ALUOP_W(ALUOP_W), .MDU_LAT(MDU_LAT), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    bit rw, mtr, mw, as, rd;
    int aop;
    bit mdu, hilo, br;
    int cond;
    bit j, jr, ill;
  } dec_t;

  typedef struct {
    bit rw, mtr, mw, as, rd;
    int aop;
  } stage_t;

  stage_t st_e, st_m, st_w;
  bit     st_start;
  int     cyc;
  int     mdu_end;
  int     compared   = 0;
  int     mismatched = 0;
  bit     obs_stall;
  int     imm_aop [8:15] = '{0, 0, 7, 6, 3, 4, 5, 1};

  logic [5:0] rfn [25] = '{6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, 6'h08, 6'h10, 6'h12,
                           6'h18, 6'h19, 6'h1a, 6'h1b, 6'h20, 6'h21, 6'h22, 6'h23, 6'h24,
                           6'h25, 6'h26, 6'h27, 6'h2a, 6'h2b, 6'h01, 6'h3f};
  logic [5:0] iop [19] = '{6'h08, 6'h09, 6'h0a, 6'h0b, 6'h0c, 6'h0d, 6'h0e, 6'h0f, 6'h23,
                           6'h2b, 6'h04, 6'h05, 6'h06, 6'h07, 6'h01, 6'h02, 6'h03, 6'h3f, 6'h20};

  function automatic dec_t ref_decode(logic [5:0] op, logic [5:0] fn, logic [4:0] rt);
    dec_t d;
    d = '{default: 0};
    if (op == 6'h00) begin
      if (fn == 6'h08) begin
        d.j = 1; d.jr = 1;
      end else if (fn inside {6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, 6'h10, 6'h12,
                              [6'h18:6'h1b], [6'h20:6'h27], 6'h2a, 6'h2b}) begin
        d.rd   = 1;
        d.aop  = 2;
        d.mdu  = fn inside {[6'h18:6'h1b]};
        d.hilo = fn inside {6'h10, 6'h12};
        d.rw   = !d.mdu;
      end else begin
        d.ill = 1;
      end
    end else if (op inside {[6'h08:6'h0f]}) begin
      d.rw = 1; d.as = 1; d.aop = imm_aop[int'(op)];
    end else if (op == 6'h23) begin
      d.rw = 1; d.mtr = 1; d.as = 1;
    end else if (op == 6'h2b) begin
      d.mw = 1; d.as = 1;
    end else if (op inside {[6'h04:6'h07]}) begin
      d.br = 1; d.cond = int'(op) - 4;
    end else if (op == 6'h01 && rt < 5'd2) begin
      d.br = 1; d.cond = 4 + int'(rt);
    end else if (op == 6'h02) begin
      d.j = 1;
    end else begin
      d.ill = 1;
    end
    return d;
  endfunction

  task automatic model_reset();
    st_e     = '{default: 0};
    st_m     = '{default: 0};
    st_w     = '{default: 0};
    st_start = 0;
    mdu_end  = 0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_all(input dec_t d, input bit stall_m);
    chk("branch_d",     bus.branch_d,     d.br);
    chk("br_cond_d",    bus.br_cond_d,    d.br ? d.cond : 0);
    chk("jump_d",       bus.jump_d,       d.j);
    chk("jump_r_d",     bus.jump_r_d,     d.jr);
    chk("illegal_d",    bus.illegal_d,    d.ill);
    chk("mdu_stall",    bus.mdu_stall,    stall_m);
    chk("reg_write_e",  bus.reg_write_e,  st_e.rw);
    chk("mem_to_reg_e", bus.mem_to_reg_e, st_e.mtr);
    chk("mem_write_e",  bus.mem_write_e,  st_e.mw);
    chk("alu_src_e",    bus.alu_src_e,    st_e.as);
    chk("reg_dst_e",    bus.reg_dst_e,    st_e.rd);
    chk("alu_op_e",     bus.alu_op_e,     st_e.aop);
    chk("reg_write_m",  bus.reg_write_m,  st_m.rw);
    chk("mem_to_reg_m", bus.mem_to_reg_m, st_m.mtr);
    chk("mem_write_m",  bus.mem_write_m,  st_m.mw);
    chk("reg_write_w",  bus.reg_write_w,  st_w.rw);
    chk("mem_to_reg_w", bus.mem_to_reg_w, st_w.mtr);
    chk("mdu_start_e",  bus.mdu_start_e,  st_start);
    chk("mdu_busy",     bus.mdu_busy,     cyc < mdu_end);
  endtask

  task automatic drive(input logic [5:0] op, input logic [5:0] fn, input logic [4:0] rt,
                       input logic st, input logic fl);
    bus.op      = op;
    bus.funct   = fn;
    bus.rt      = rt;
    bus.stall_e = st;
    bus.flush_e = fl;
  endtask

  // Called at a falling edge with inputs applied; returns at the next falling edge.
  task automatic tick();
    dec_t d;
    bit   stall_m;
    #1;
    if (rst) model_reset();
    d         = ref_decode(bus.op, bus.funct, bus.rt);
    stall_m   = (cyc < mdu_end) && (d.mdu || d.hilo);
    obs_stall = bus.mdu_stall;
    check_all(d, stall_m);
    @(posedge clk);
    cyc++;
    if (rst) begin
      model_reset();
    end else if (bus.stall_e) begin
      st_start = 0;
    end else begin
      st_w = st_m;
      st_m = st_e;
      if (bus.flush_e || stall_m) begin
        st_e     = '{default: 0};
        st_start = 0;
      end else begin
        st_e     = '{d.rw, d.mtr, d.mw, d.as, d.rd, d.aop};
        st_start = d.mdu;
        if (d.mdu) mdu_end = cyc + MDU_LAT;
      end
    end
    @(negedge clk);
  endtask

  initial begin
    int n;
    rst = 1'b1;
    cyc = 0;
    model_reset();
    drive(6'h00, 6'h20, 5'd0, 1'b0, 1'b0);
    @(negedge clk);
    tick();
    tick();
    rst = 1'b0;

    // MULT in flight, then an asynchronous reset between edges
    drive(6'h00, 6'h18, 5'd0, 1'b0, 1'b0); tick();
    drive(6'h08, 6'h00, 5'd0, 1'b0, 1'b0); tick();
    drive(6'h00, 6'h21, 5'd0, 1'b0, 1'b0); tick();
    chk("busy_before_rst", bus.mdu_busy, 1);
    rst = 1'b1;
    #2;
    chk("rst_async_reg_write_e", bus.reg_write_e, 0);
    chk("rst_async_reg_write_m", bus.reg_write_m, 0);
    chk("rst_async_alu_src_e",   bus.alu_src_e,   0);
    chk("rst_async_mdu_busy",    bus.mdu_busy,    0);
    tick();
    rst = 1'b0;

    // addi latency through E and W
    drive(6'h08, 6'h00, 5'd0, 1'b0, 1'b0); tick();
    chk("addi_reg_write_e", bus.reg_write_e, 1);
    chk("addi_alu_src_e",   bus.alu_src_e,   1);
    chk("addi_alu_op_e",    bus.alu_op_e,    0);
    drive(6'h2b, 6'h00, 5'd0, 1'b0, 1'b0); tick(); tick();
    chk("addi_reg_write_w", bus.reg_write_w, 1);
    tick();
    chk("sw_reg_write_w", bus.reg_write_w, 0);

    // REGIMM conditions and the set-less-than variants
    drive(6'h01, 6'h00, 5'd1, 1'b0, 1'b0); tick();
    chk("bgez_branch_d", bus.branch_d, 1);
    chk("bgez_cond",     bus.br_cond_d, 5);
    drive(6'h01, 6'h00, 5'd0, 1'b0, 1'b0); tick();
    chk("bltz_cond", bus.br_cond_d, 4);
    drive(6'h0b, 6'h00, 5'd0, 1'b0, 1'b0); tick();
    chk("sltiu_alu_op_e", bus.alu_op_e, 6);
    drive(6'h0a, 6'h00, 5'd0, 1'b0, 1'b0); tick();
    chk("slti_alu_op_e", bus.alu_op_e, 7);

    // lw held by stall_e for two edges, then released
    drive(6'h23, 6'h00, 5'd0, 1'b0, 1'b0); tick();
    drive(6'h08, 6'h00, 5'd0, 1'b1, 1'b0);
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("hold_mem_to_reg_e", bus.mem_to_reg_e, 1);
      chk("hold_mem_to_reg_m", bus.mem_to_reg_m, 0);
      chk("hold_mem_to_reg_w", bus.mem_to_reg_w, 0);
    end
    drive(6'h2b, 6'h00, 5'd0, 1'b0, 1'b0); tick();
    chk("rel_mem_to_reg_e", bus.mem_to_reg_e, 0);
    chk("rel_mem_to_reg_m", bus.mem_to_reg_m, 1);
    tick();
    chk("rel_mem_to_reg_w", bus.mem_to_reg_w, 1);

    // MULT followed by mflo: interlock length and bubble insertion
    drive(6'h00, 6'h18, 5'd0, 1'b0, 1'b0); tick();
    chk("mult_start_e", bus.mdu_start_e, 1);
    chk("mult_busy",    bus.mdu_busy,    1);
    drive(6'h00, 6'h12, 5'd0, 1'b0, 1'b0);
    n = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (obs_stall) n++;
      else break;
    end
    chk("mflo_stall_cycles", n, MDU_LAT);
    chk("mflo_in_e_reg_write", bus.reg_write_e, 1);
    chk("mflo_in_e_busy",      bus.mdu_busy,    0);

    // start pulse does not repeat while E is held
    drive(6'h00, 6'h19, 5'd0, 1'b0, 1'b0); tick();
    drive(6'h00, 6'h10, 5'd0, 1'b1, 1'b0); tick();
    chk("held_start_e", bus.mdu_start_e, 0);
    chk("held_busy",    bus.mdu_busy,    1);
    drive(6'h08, 6'h00, 5'd0, 1'b0, 1'b0);
    for (int i = 0; i < MDU_LAT; i++) tick();

    // flush beats an entering DIV
    drive(6'h00, 6'h1a, 5'd0, 1'b0, 1'b1); tick();
    chk("flush_alu_op_e",    bus.alu_op_e,    0);
    chk("flush_reg_write_e", bus.reg_write_e, 0);
    chk("flush_start_e",     bus.mdu_start_e, 0);
    chk("flush_busy",        bus.mdu_busy,    0);
    drive(6'h08, 6'h00, 5'd0, 1'b0, 1'b0); tick();
    chk("flush_busy_after", bus.mdu_busy, 0);

    // illegal opcode and jr
    drive(6'h3f, 6'h00, 5'd0, 1'b0, 1'b0); tick();
    chk("illegal_d",          bus.illegal_d,   1);
    chk("illegal_reg_write_e", bus.reg_write_e, 0);
    chk("illegal_alu_src_e",   bus.alu_src_e,   0);
    chk("illegal_alu_op_e",    bus.alu_op_e,    0);
    drive(6'h00, 6'h08, 5'd0, 1'b0, 1'b0); tick();
    chk("jr_jump_d",      bus.jump_d,      1);
    chk("jr_jump_r_d",    bus.jump_r_d,    1);
    chk("jr_reg_write_e", bus.reg_write_e, 0);

    // random traffic, model-checked every cycle
    for (int i = 0; i < 400; i++) begin
      logic [5:0] op;
      logic [5:0] fn;
      logic [4:0] rt;
      if ($urandom_range(0, 9) < 4) begin
        op = 6'h00;
        fn = rfn[$urandom_range(0, 24)];
      end else begin
        op = iop[$urandom_range(0, 18)];
        fn = 6'($urandom_range(0, 63));
      end
      rt  = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 1));
      rst = ($urandom_range(0, 99) == 0);
      drive(op, fn, rt, $urandom_range(0, 7) == 0, $urandom_range(0, 9) == 0);
      tick();
    end
    rst = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
